oc8051_cxrom_prefetch: RTL and testbench
========================================

Name: oc8051_cxrom_prefetch

Overview:
- Instruction-fetch initiator for the fully combinational 32-bit code ROM port, sitting between the oc8051 core and the ROM.
- Drives the ROM byte address and captures 4 little-endian bytes per access into a circular byte queue.
- Presents the core with a 4-byte window aligned to the current PC, supports variable-length consumption of 0..4 bytes per cycle, and flushes on a PC redirect such as a jump, call, return or interrupt.

Parameters:
- QDEPTH, 8, queue capacity in bytes; power of two, >= 8.
- AW, 16, code address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- cxrom_addr  output  AW  ROM byte address; registered, equals fetch pointer
- cxrom_data_in  input  32  ROM data; byte at cxrom_addr in [7:0], addr+1 in [15:8], and so on; valid same cycle
- redirect  input  1  flush queue and restart fetch at redirect_pc
- redirect_pc  input  AW  new PC, sampled when redirect=1
- consume  input  3  bytes taken by core this cycle (0..4)
- op_data  output  32  head byte in [7:0], head+1 in [15:8], head+2 in [23:16], head+3 in [31:24]
- op_avail  output  3  min(count,4): number of valid bytes in op_data
- pc_head  output  AW  code address of the head byte

Behaviour:
- State:
  - fetch_ptr[AW-1:0]
  - pc_head[AW-1:0]
  - head and tail pointers, log2(QDEPTH) bits each, wrap mod QDEPTH
  - count, 0..QDEPTH
  - byte array
- Reset (async, rst=1): fetch_ptr=0, pc_head=0, head=tail=0, count=0; hence cxrom_addr=0, op_avail=0, op_data=0. Reset asserted mid-operation discards all queue contents immediately.
- fetch_ok = (QDEPTH - count) >= 4, evaluated on current count, before this cycle's consume.
- eff = min(consume, op_avail). Over-consumption is clamped, never underflows.
- Priority 1, redirect=1:
  - fetch_ptr <= redirect_pc, pc_head <= redirect_pc, head=tail=0, count=0.
  - ROM data this cycle is discarded; consume is ignored.
- Priority 2, normal cycle:
  - If fetch_ok: write cxrom_data_in bytes 0..3 to queue[tail..tail+3] (mod QDEPTH), tail += 4, fetch_ptr += 4 (wraps mod 2^AW: 0xFFFC -> 0x0000).
  - Otherwise hold fetch_ptr and the queue.
  - Consume: head += eff, pc_head += eff (wraps mod 2^AW).
  - count_next = count + (fetch_ok ? 4 : 0) - eff. Simultaneous fetch and consume is legal and always in range.
- Outputs (combinational from registered state):
  - op_avail = min(count,4).
  - op_data bytes at positions >= op_avail are driven 8'h00.
- Latency:
  - Redirect asserted in cycle N -> cxrom_addr=redirect_pc in N+1 -> op_avail=4, pc_head=redirect_pc in N+2.
  - After reset release: the first cycle fetches address 0; op_avail=4 in the next cycle.
- Steady state with no consumption: the queue fills to QDEPTH after QDEPTH/4 fetches and fetching stalls. Fetching resumes in the cycle after count drops to <= QDEPTH-4.
- No range checking of ROM address; out-of-range ROM data (x) is stored as-is.
- Invariant: fetch_ptr - pc_head == count (mod 2^AW) at every clock edge; the bench asserts it.

Test Plan:
- Reset, release, ROM[0..7]=00..07, consume=0 -> cxrom_addr 0x0000 then 0x0004 then holds 0x0008; op_avail=4, op_data=0x03020100, pc_head=0; count reaches 8 and fetching stalls.
- Steady consume=1 from the filled queue -> op_data successively 0x04030201, 0x05040302, and so on; pc_head increments by 1 per cycle; fetch resumes once count <= 4; op_avail never drops below 4.
- Redirect to 0x1234 with consume=3 in the same cycle -> consume ignored; next cycle op_avail=0, cxrom_addr=0x1234; following cycle op_data = ROM[0x1237..0x1234], pc_head=0x1234.
- Redirect to 0xFFFC -> cxrom_addr sequence 0xFFFC, 0x0000, 0x0004; consume=4 twice -> pc_head 0xFFFC -> 0x0000 -> 0x0004.
- consume=4 when op_avail=2 (one cycle after a redirect with fetch blocked by a forced full state) -> eff=2, count never negative, pc_head += 2; and consume=4 with fetch active each cycle -> count stays constant.
- Assert rst asynchronously between clock edges mid-stream -> outputs zero immediately, before the next edge; first fetch after release at 0x0000.

Source files
------------

// File: rtl/oc8051_cxrom_prefetch.sv
// rtl/oc8051_cxrom_prefetch.sv - code ROM instruction prefetch queue for the oc8051 core
// Fetches 4 bytes per access into a circular byte queue and presents a PC-aligned 4-byte window.
module oc8051_cxrom_prefetch #(
   parameter int QDEPTH = 8,
   parameter int AW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] cxrom_addr,
   input  logic [31:0]   cxrom_data_in,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic [2:0]    consume,
   output logic [31:0]   op_data,
   output logic [2:0]    op_avail,
   output logic [AW-1:0] pc_head
);

   localparam int PW = $clog2(QDEPTH);

   logic [AW-1:0] fetch_ptr;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic [7:0]    queue [QDEPTH];
   logic          fetch_ok;
   logic [2:0]    eff;

   // Room for a whole 4-byte access is judged on the count before this cycle's consumption.
   assign fetch_ok   = (32'(count) + 32'd4) <= 32'(QDEPTH);
   assign op_avail   = (count >= (PW+1)'(4)) ? 3'd4 : count[2:0];
   assign eff        = (consume < op_avail) ? consume : op_avail;
   assign cxrom_addr = fetch_ptr;

   always_comb begin
      op_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < op_avail)
            op_data[8*i +: 8] = queue[head + PW'(i)];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_ptr <= '0;
         pc_head   <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else if (redirect) begin
         fetch_ptr <= redirect_pc;
         pc_head   <= redirect_pc;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         if (fetch_ok) begin
            tail      <= tail + PW'(4);
            fetch_ptr <= fetch_ptr + AW'(4);
         end
         head    <= head + PW'(eff);
         pc_head <= pc_head + AW'(eff);
         count   <= count + (fetch_ok ? (PW+1)'(4) : (PW+1)'(0)) - (PW+1)'(eff);
      end
   end

   // Byte storage needs no reset: bytes beyond count are masked off at the output.
   always_ff @(posedge clk) begin
      if (!redirect && fetch_ok) begin
         for (int i = 0; i < 4; i++)
            queue[tail + PW'(i)] <= cxrom_data_in[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
// tb/tb_oc8051_cxrom_prefetch.sv - self-checking bench for the code ROM prefetch queue
// Reference model tracks fetch address, head PC and byte count; window contents come from the ROM image.
module tb_oc8051_cxrom_prefetch;

   localparam int AW     = 16;
   localparam int QDEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] cxrom_addr;
   logic [31:0]   cxrom_data_in;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [2:0]    consume = 3'd0;
   logic [31:0]   op_data;
   logic [2:0]    op_avail;
   logic [AW-1:0] pc_head;

   int n_cmp = 0;
   int n_bad = 0;

   logic [AW-1:0] m_fp;
   logic [AW-1:0] m_pc;
   int            m_cnt;

   oc8051_cxrom_prefetch #(.QDEPTH(QDEPTH), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cxrom_addr   (cxrom_addr),
      .cxrom_data_in(cxrom_data_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .consume      (consume),
      .op_data      (op_data),
      .op_avail     (op_avail),
      .pc_head      (pc_head)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   assign cxrom_data_in = {rom(cxrom_addr + 16'd3), rom(cxrom_addr + 16'd2),
                           rom(cxrom_addr + 16'd1), rom(cxrom_addr)};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int m_avail();
      return (m_cnt > 4) ? 4 : m_cnt;
   endfunction

   function automatic logic [31:0] m_window();
      logic [31:0] d;
      d = 32'h0;
      for (int i = 0; i < m_avail(); i++)
         d[8*i +: 8] = rom(m_pc + AW'(i));
      return d;
   endfunction

   task automatic model_reset();
      m_fp  = '0;
      m_pc  = '0;
      m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  32'(cxrom_addr), 32'(m_fp));
      check({tag, ".pc"},    32'(pc_head),    32'(m_pc));
      check({tag, ".avail"}, 32'(op_avail),   32'(m_avail()));
      check({tag, ".data"},  op_data,         m_window());
      check({tag, ".inv"},   32'(AW'(cxrom_addr - pc_head)), 32'(m_cnt));
      if (m_cnt < 0 || m_cnt > QDEPTH)
         check({tag, ".range"}, 32'(m_cnt), 32'(QDEPTH));
   endtask

   // Drive one cycle of inputs from the falling edge, advance the model across the rising edge.
   task automatic step(input string tag, input logic r, input logic [AW-1:0] rpc, input logic [2:0] c);
      int eff;
      redirect    = r;
      redirect_pc = rpc;
      consume     = c;
      @(posedge clk);
      eff = (int'(c) < m_avail()) ? int'(c) : m_avail();
      if (r) begin
         m_fp  = rpc;
         m_pc  = rpc;
         m_cnt = 0;
      end else begin
         if (QDEPTH - m_cnt >= 4) begin
            m_fp  = m_fp + AW'(4);
            m_cnt = m_cnt + 4;
         end
         m_pc  = m_pc + AW'(eff);
         m_cnt = m_cnt - eff;
      end
      @(negedge clk);
      redirect = 1'b0;
      consume  = 3'd0;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst.addr",  32'(cxrom_addr), 32'h0);
      check("rst.avail", 32'(op_avail),   32'h0);
      check("rst.data",  op_data,         32'h0);
      check("rst.pc",    32'(pc_head),    32'h0);
      rst = 1'b0;

      step("fill0", 1'b0, '0, 3'd0);
      check("fill0.addr4", 32'(cxrom_addr), 32'h4);
      check("fill0.data",  op_data,         32'h03020100);
      check("fill0.avail", 32'(op_avail),   32'd4);
      step("fill1", 1'b0, '0, 3'd0);
      check("fill1.addr8", 32'(cxrom_addr), 32'h8);
      step("fill2", 1'b0, '0, 3'd0);
      check("stall.addr8", 32'(cxrom_addr), 32'h8);

      step("c1a", 1'b0, '0, 3'd1);
      check("c1a.data", op_data, 32'h04030201);
      step("c1b", 1'b0, '0, 3'd1);
      check("c1b.data", op_data, 32'h05040302);
      for (int i = 0; i < 8; i++) step("c1", 1'b0, '0, 3'd1);

      step("rd1234", 1'b1, 16'h1234, 3'd3);
      check("rd1234.avail0", 32'(op_avail),   32'd0);
      check("rd1234.addr",   32'(cxrom_addr), 32'h1234);
      step("rd1234n", 1'b0, '0, 3'd0);
      check("rd1234n.pc",   32'(pc_head), 32'h1234);
      check("rd1234n.data", op_data,      32'h25242726);

      step("wrap0", 1'b1, 16'hFFFC, 3'd0);
      check("wrap0.addr", 32'(cxrom_addr), 32'hFFFC);
      step("wrap1", 1'b0, '0, 3'd0);
      check("wrap1.addr", 32'(cxrom_addr), 32'h0000);
      check("wrap1.pc",   32'(pc_head),    32'hFFFC);
      step("wrap2", 1'b0, '0, 3'd4);
      check("wrap2.pc",   32'(pc_head),    32'h0000);
      check("wrap2.addr", 32'(cxrom_addr), 32'h0004);
      step("wrap3", 1'b0, '0, 3'd4);
      check("wrap3.pc",   32'(pc_head),    32'h0004);

      step("low0", 1'b1, 16'h0100, 3'd0);
      step("low1", 1'b0, '0, 3'd0);
      step("low2", 1'b0, '0, 3'd0);
      step("low3", 1'b0, '0, 3'd3);
      step("low4", 1'b0, '0, 3'd3);
      check("low4.avail2", 32'(op_avail), 32'd2);
      step("over", 1'b0, '0, 3'd4);
      check("over.pc",    32'(pc_head),  32'h0108);
      check("over.avail", 32'(op_avail), 32'd4);
      for (int i = 0; i < 4; i++) step("c4", 1'b0, '0, 3'd4);

      for (int i = 0; i < 400; i++) begin
         logic          r;
         logic [AW-1:0] rpc;
         logic [2:0]    c;
         r   = ($urandom_range(0, 15) == 0);
         rpc = AW'($urandom);
         c   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         step("rnd", r, rpc, c);
      end

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst.addr",  32'(cxrom_addr), 32'h0);
      check("arst.avail", 32'(op_avail),   32'h0);
      check("arst.data",  op_data,         32'h0);
      check("arst.pc",    32'(pc_head),    32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check_all("arst.rel");
      step("arst.f0", 1'b0, '0, 3'd0);
      check("arst.f0.addr", 32'(cxrom_addr), 32'h4);
      check("arst.f0.data", op_data,         32'h03020100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
